// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, issues single-outstanding word
// requests to instruction memory and presents {pc, next_pc, valid, inst} to decode.
module fetch_stage #(
    parameter logic [63:0] RESET_ADDR = 64'h0000_0000_0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [63:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        valid_o,
    output logic [63:0] pc_o,
    output logic [63:0] next_pc_o,
    output logic [31:0] inst_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [63:0] inflight_pc_q, inflight_pc_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic        discard_q, discard_d;
    logic        rsp;
    logic [63:0] redir_pc;

    assign redir_pc    = {redirect_pc_i[63:2], 2'b00};
    assign rsp         = (state_q == S_WAIT) && imem_rvalid_i && !rst_i;
    assign pc_o        = inflight_pc_q;
    assign next_pc_o   = inflight_pc_q + 64'd4;
    assign inst_o      = rsp ? imem_rdata_i : hold_inst_q;
    assign imem_addr_o = fetch_pc_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        hold_inst_d   = hold_inst_q;
        discard_d     = discard_q;
        imem_req_o    = 1'b0;
        valid_o       = 1'b0;

        if (redirect_i) begin
            fetch_pc_d = redir_pc;
            case (state_q)
                // A grant seen alongside a redirect belongs to the old path.
                S_REQ: if (imem_gnt_i) begin
                    discard_d = 1'b1;
                    state_d   = S_WAIT;
                end
                S_WAIT: if (imem_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = S_REQ;
                end else begin
                    discard_d = 1'b1;
                end
                default: begin
                    hold_inst_d = '0;
                    state_d     = S_REQ;
                end
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    imem_req_o = 1'b1;
                    if (imem_gnt_i) begin
                        inflight_pc_d = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + 64'd4;
                        state_d       = S_WAIT;
                    end
                end
                S_WAIT: if (rsp) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        valid_o = 1'b1;
                        if (!stall_i) begin
                            // Decode takes the word now, so the next request goes out this cycle.
                            imem_req_o = 1'b1;
                            if (imem_gnt_i) begin
                                inflight_pc_d = fetch_pc_q;
                                fetch_pc_d    = fetch_pc_q + 64'd4;
                            end else begin
                                state_d = S_REQ;
                            end
                        end else begin
                            hold_inst_d = imem_rdata_i;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    valid_o = 1'b1;
                    if (!stall_i) state_d = S_REQ;
                end
                default: state_d = S_REQ;
            endcase
        end

        if (rst_i) begin
            imem_req_o = 1'b0;
            valid_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_ADDR;
            inflight_pc_q <= RESET_ADDR;
            hold_inst_q   <= '0;
            discard_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            hold_inst_q   <= hold_inst_d;
            discard_q     <= discard_d;
        end
    end

endmodule
